pcie_tx_vc0_arbiter: RTL and testbench
======================================

Name: pcie_tx_vc0_arbiter

Overview:
Shares the PCIe core's single VC0 transmit TLP port between NSRC user requesters (e.g. DMA write, completion, MSI/message engines).
- Round-robin arbitration, gated by the core's advertised credits.
- Runs the tx_req/tx_rdy handshake with the core.
- Muxes the granted requester's 16-bit beat stream onto tx_data_vc0 with framing.
- Sits between user TLP engines and pcie_x1_core, in the 125 MHz domain.

Parameters:
NSRC, 3, number of requesters (2..8)
TIMEOUT, 1024, cycles allowed in REQ waiting for tx_rdy_vc0 before abort
TOW, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridable)

Ports:
sys_clk_125  in  1  core clock
rst_n  in  1  asynchronous active-low reset
dl_up  in  1  data link layer up
src_req  in  NSRC  requester has complete TLP ready
src_cls  in  2*NSRC  credit class per source: 0 posted, 1 non-posted, 2 completion, 3 reserved (never eligible)
src_dcred  in  9*NSRC  data credits (16-byte units) the TLP needs; 0 = no payload
src_data  in  16*NSRC  beat data, valid every cycle while src_rd asserted
src_end  in  NSRC  current beat is last
src_nlfy  in  NSRC  nullify this TLP (sampled with src_end)
src_gnt  out  NSRC  one-hot grant, held REQ through last XFER beat
src_rd  out  NSRC  beat consumed this cycle
src_abort  out  NSRC  one-cycle pulse, granted TLP abandoned
tx_rdy_vc0  in  1  core ready
tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0  in  9  header credits; bit 8 = infinite
tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0  in  13  data credits; bit 12 = infinite
tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0  in  1  credit recheck request
tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0  out  1  core TX control
tx_data_vc0  out  16  core TX data
arb_busy  out  1  state != IDLE
arb_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE, rr pointer = NSRC-1 (so source 0 wins first), all outputs 0, watchdog 0.
- Eligible[i] = src_req[i] & dl_up & cls != 3 & hdr credit of class nonzero (bit8 or [7:0]!=0) & (data credit bit12 or [11:0] >= src_dcred[i]). Non-posted data uses npd.
- IDLE: if any eligible, pick first eligible after rr pointer (wrap-around). Register gnt, go REQ. tx_req_vc0 goes high the next cycle (1-cycle latency from src_req).
- REQ: tx_req_vc0=1; watchdog increments.
  - tx_rdy_vc0=1 -> XFER.
  - Recheck input for the granted class (p covers P and NP; cpl covers CPL) high -> back to IDLE, no abort, pointer unchanged.
  - Watchdog reaches TIMEOUT -> IDLE, arb_timeout and src_abort pulse.
- XFER: tx_req_vc0=0. Every cycle src_rd[g]=1 and tx_data_vc0=src_data[g] (combinational mux on registered gnt).
  - tx_st_vc0=1 on first XFER cycle only.
  - tx_end_vc0=src_end[g]; tx_nlfy_vc0=src_end[g]&src_nlfy[g].
  - On end: gnt cleared, rr pointer = g, state IDLE. Next arbitration is possible the following cycle.
  - Single-beat TLP: st and end in the same cycle.
- dl_up low in REQ or XFER: next cycle IDLE, src_abort[g] pulse, no tx_end. The core flushes on link down.
- tx_data_vc0 = 0 outside XFER.
- Simultaneous src_end and dl_up fall: the end beat completes normally; no abort.

Decomposition:
- Package pcie_tx_arb_pkg: class codes (CLS_P, CLS_NP, CLS_CPL), state enum (IDLE, REQ, XFER), infinite-credit bit positions.
- Sub-module pcie_rr_pick: NSRC-wide round-robin picker (req vector, pointer -> one-hot grant, valid).

Test Plan:
- src_req=3'b111, all credits infinite, 4-beat TLPs -> grants 0,1,2,0 in order; tx_st on beat 1, tx_end on beat 4; tx_req high exactly 1 cycle per TLP when tx_rdy returns immediately.
- Source 0 posted with dcred=8, tx_ca_pd=5, source 1 completion -> source 1 granted; raise pd to 8 -> source 0 granted next.
- Hold tx_rdy_vc0=0 with TIMEOUT=16 -> tx_req high 16 cycles, then arb_timeout and src_abort[g] pulse, arb_busy=0.
- Assert tx_ca_p_recheck_vc0 in REQ for a posted TLP -> returns IDLE, no abort, re-arbitrates same source next.
- Drop dl_up on XFER beat 2 -> src_abort pulse, no tx_end_vc0, nothing granted until dl_up=1.
- 1-beat nullified TLP -> tx_st, tx_end, tx_nlfy all high the same cycle.

Source files
------------

// File: rtl/pcie_tx_arb_pkg.sv
// Shared credit-class codes, arbiter state encoding and credit helpers
// for the PCIe VC0 transmit arbiter.
package pcie_tx_arb_pkg;

    localparam logic [1:0] CLS_P   = 2'd0;
    localparam logic [1:0] CLS_NP  = 2'd1;
    localparam logic [1:0] CLS_CPL = 2'd2;
    localparam logic [1:0] CLS_RSV = 2'd3;

    localparam int HDR_INF_BIT = 8;
    localparam int DAT_INF_BIT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

    // A TLP fits when one header credit exists and the data credits cover its payload.
    function automatic logic credit_ok(input logic [8:0]  hdr,
                                       input logic [12:0] dat,
                                       input logic [8:0]  need);
        logic hdr_ok;
        logic dat_ok;
        hdr_ok = hdr[HDR_INF_BIT] || (hdr[7:0] != 8'd0);
        dat_ok = dat[DAT_INF_BIT] || (dat[11:0] >= {3'b000, need});
        return hdr_ok && dat_ok;
    endfunction

endpackage

// File: rtl/pcie_tx_vc0_arbiter_if.sv
// Transmit-side signals between the VC0 arbiter (master) and the PCIe core (slave).
interface pcie_tx_vc0_arbiter_if;
    logic        tx_rdy_vc0;
    logic [8:0]  tx_ca_ph_vc0;
    logic [8:0]  tx_ca_nph_vc0;
    logic [8:0]  tx_ca_cplh_vc0;
    logic [12:0] tx_ca_pd_vc0;
    logic [12:0] tx_ca_npd_vc0;
    logic [12:0] tx_ca_cpld_vc0;
    logic        tx_ca_p_recheck_vc0;
    logic        tx_ca_cpl_recheck_vc0;
    logic        tx_req_vc0;
    logic        tx_st_vc0;
    logic        tx_end_vc0;
    logic        tx_nlfy_vc0;
    logic [15:0] tx_data_vc0;

    modport master (
        input  tx_rdy_vc0,
        input  tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0,
        input  tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0,
        input  tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0,
        output tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, tx_data_vc0
    );

    modport slave (
        output tx_rdy_vc0,
        output tx_ca_ph_vc0, tx_ca_nph_vc0, tx_ca_cplh_vc0,
        output tx_ca_pd_vc0, tx_ca_npd_vc0, tx_ca_cpld_vc0,
        output tx_ca_p_recheck_vc0, tx_ca_cpl_recheck_vc0,
        input  tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, tx_data_vc0
    );
endinterface

// File: rtl/pcie_rr_pick.sv
// Round-robin picker: grants the first requester strictly after the pointer, wrapping.
module pcie_rr_pick #(
    parameter int NSRC = 3
) (
    input  logic [NSRC-1:0]         i_req,
    input  logic [$clog2(NSRC)-1:0] i_ptr,
    output logic [NSRC-1:0]         o_gnt,
    output logic [$clog2(NSRC)-1:0] o_idx,
    output logic                    o_vld
);
    localparam int PW = $clog2(NSRC);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        // Upper half above the pointer first, then wrap to the lowest index.
        for (int j = 0; j < NSRC; j++) begin
            if (!o_vld && i_req[j] && (j > int'(i_ptr))) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = PW'(j);
            end
        end
        for (int j = 0; j < NSRC; j++) begin
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = PW'(j);
            end
        end
    end
endmodule

// File: rtl/pcie_tx_vc0_arbiter.sv
// Credit-gated round-robin arbiter sharing the core's VC0 TLP transmit port
// between NSRC requesters; runs tx_req/tx_rdy and muxes the granted beat stream.
module pcie_tx_vc0_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int NSRC    = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 sys_clk_125,
    input  logic                 rst_n,
    input  logic                 dl_up,
    input  logic [NSRC-1:0]      src_req,
    input  logic [2*NSRC-1:0]    src_cls,
    input  logic [9*NSRC-1:0]    src_dcred,
    input  logic [16*NSRC-1:0]   src_data,
    input  logic [NSRC-1:0]      src_end,
    input  logic [NSRC-1:0]      src_nlfy,
    output logic [NSRC-1:0]      src_gnt,
    output logic [NSRC-1:0]      src_rd,
    output logic [NSRC-1:0]      src_abort,
    pcie_tx_vc0_arbiter_if.master tx,
    output logic                 arb_busy,
    output logic                 arb_timeout
);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam int PW  = $clog2(NSRC);

    arb_state_e      r_state;
    logic [NSRC-1:0] r_gnt;
    logic [PW-1:0]   r_gidx;
    logic [PW-1:0]   r_ptr;
    logic [1:0]      r_cls;
    logic [TOW-1:0]  r_wd;
    logic            r_req;
    logic            r_first;
    logic [NSRC-1:0] r_abort;
    logic            r_timeout;

    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_pick_gnt;
    logic [PW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic            w_xfer;
    logic            w_end;
    logic            w_recheck;
    logic [TOW-1:0]  w_wd_inc;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NSRC; i++) begin
            case (src_cls[2*i +: 2])
                CLS_P:   w_elig[i] = credit_ok(tx.tx_ca_ph_vc0, tx.tx_ca_pd_vc0, src_dcred[9*i +: 9]);
                CLS_NP:  w_elig[i] = credit_ok(tx.tx_ca_nph_vc0, tx.tx_ca_npd_vc0, src_dcred[9*i +: 9]);
                CLS_CPL: w_elig[i] = credit_ok(tx.tx_ca_cplh_vc0, tx.tx_ca_cpld_vc0, src_dcred[9*i +: 9]);
                default: w_elig[i] = 1'b0;
            endcase
            w_elig[i] = w_elig[i] & src_req[i] & dl_up;
        end
    end

    pcie_rr_pick #(.NSRC(NSRC)) u_pick (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // The posted recheck also covers non-posted; completions have their own.
    assign w_recheck = (r_cls == CLS_CPL) ? tx.tx_ca_cpl_recheck_vc0 : tx.tx_ca_p_recheck_vc0;
    assign w_wd_inc  = r_wd + TOW'(1);
    assign w_xfer    = (r_state == XFER);
    assign w_end     = w_xfer & src_end[r_gidx];

    assign tx.tx_req_vc0  = r_req;
    assign tx.tx_st_vc0   = w_xfer & r_first;
    assign tx.tx_end_vc0  = w_end;
    assign tx.tx_nlfy_vc0 = w_end & src_nlfy[r_gidx];
    assign tx.tx_data_vc0 = w_xfer ? src_data[16*r_gidx +: 16] : 16'h0000;

    assign src_gnt     = r_gnt;
    assign src_rd      = w_xfer ? r_gnt : '0;
    assign src_abort   = r_abort;
    assign arb_timeout = r_timeout;
    assign arb_busy    = (r_state != IDLE);

    always_ff @(posedge sys_clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gidx    <= '0;
            r_ptr     <= PW'(NSRC - 1);
            r_cls     <= CLS_P;
            r_wd      <= '0;
            r_req     <= 1'b0;
            r_first   <= 1'b0;
            r_abort   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_abort   <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state <= REQ;
                        r_gnt   <= w_pick_gnt;
                        r_gidx  <= w_pick_idx;
                        r_cls   <= src_cls[2*w_pick_idx +: 2];
                        r_req   <= 1'b1;
                        r_wd    <= '0;
                    end
                end
                REQ: begin
                    if (!dl_up) begin
                        r_state <= IDLE;
                        r_abort <= r_gnt;
                        r_gnt   <= '0;
                        r_req   <= 1'b0;
                        r_wd    <= '0;
                    end else if (tx.tx_rdy_vc0) begin
                        r_state <= XFER;
                        r_req   <= 1'b0;
                        r_first <= 1'b1;
                        r_wd    <= '0;
                    end else if (w_recheck) begin
                        // Credits are being re-evaluated: drop back and re-arbitrate without penalty.
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_req   <= 1'b0;
                        r_wd    <= '0;
                    end else if (w_wd_inc == TOW'(TIMEOUT)) begin
                        r_state   <= IDLE;
                        r_abort   <= r_gnt;
                        r_timeout <= 1'b1;
                        r_gnt     <= '0;
                        r_req     <= 1'b0;
                        r_wd      <= '0;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                XFER: begin
                    r_first <= 1'b0;
                    // An end beat completes even if the link drops on the same cycle.
                    if (src_end[r_gidx]) begin
                        r_state <= IDLE;
                        r_ptr   <= r_gidx;
                        r_gnt   <= '0;
                    end else if (!dl_up) begin
                        r_state <= IDLE;
                        r_abort <= r_gnt;
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_tx_vc0_arbiter.sv
// Directed bench for pcie_tx_vc0_arbiter with a small beat-stream source model per requester.
module tb_pcie_tx_vc0_arbiter;
    localparam int NSRC    = 3;
    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 dl_up;
    logic [NSRC-1:0]      src_req;
    logic [2*NSRC-1:0]    src_cls;
    logic [9*NSRC-1:0]    src_dcred;
    logic [16*NSRC-1:0]   src_data;
    logic [NSRC-1:0]      src_end;
    logic [NSRC-1:0]      src_nlfy;
    logic [NSRC-1:0]      src_gnt;
    logic [NSRC-1:0]      src_rd;
    logic [NSRC-1:0]      src_abort;
    logic                 arb_busy;
    logic                 arb_timeout;

    pcie_tx_vc0_arbiter_if tx_if();

    pcie_tx_vc0_arbiter #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk_125 (clk),
        .rst_n       (rst_n),
        .dl_up       (dl_up),
        .src_req     (src_req),
        .src_cls     (src_cls),
        .src_dcred   (src_dcred),
        .src_data    (src_data),
        .src_end     (src_end),
        .src_nlfy    (src_nlfy),
        .src_gnt     (src_gnt),
        .src_rd      (src_rd),
        .src_abort   (src_abort),
        .tx          (tx_if.master),
        .arb_busy    (arb_busy),
        .arb_timeout (arb_timeout)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_chk;
    int n_err;
    int cnt [NSRC];
    int len [NSRC];

    // Source model: beat data is {source, beat index}; last beat flagged at len-1.
    always_comb begin
        src_data = '0;
        src_end  = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_data[16*i +: 16] = {4'(i), 12'(cnt[i])};
            src_end[i]           = (cnt[i] == len[i] - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (src_abort[i])   cnt[i] <= 0;
                else if (src_rd[i]) cnt[i] <= src_end[i] ? 0 : cnt[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        while (src_gnt == '0 && n < 40) begin
            step();
            n++;
        end
        check({tag, " grant seen"}, 32'(src_gnt != '0), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (arb_busy && n < 40) begin
            step();
            n++;
        end
        check({tag, " idle"}, 32'(arb_busy), 0);
    endtask

    // Full TLP with tx_rdy held high; req_after is applied once the grant is seen.
    task automatic run_tlp(input string tag, input int src, input int nbeat,
                           input logic [NSRC-1:0] req_after);
        int n;
        wait_gnt(tag);
        check({tag, " gnt"}, 32'(src_gnt), 1 << src);
        src_req = req_after;
        n = 0;
        while (tx_if.tx_req_vc0 && n < 8) begin
            n++;
            step();
        end
        check({tag, " req cycles"}, n, 1);
        for (int b = 0; b < nbeat; b++) begin
            check({tag, " st/end/nlfy"},
                  {tx_if.tx_st_vc0, tx_if.tx_end_vc0, tx_if.tx_nlfy_vc0},
                  {(b == 0), (b == nbeat - 1), 1'b0});
            check({tag, " data"}, 32'(tx_if.tx_data_vc0), {16'h0, 4'(src), 12'(b)});
            check({tag, " rd"}, 32'(src_rd), 1 << src);
            step();
        end
        check({tag, " busy after end"}, 32'(arb_busy), 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        dl_up = 1'b1;
        src_req = '0;
        src_cls = '0;
        src_dcred = '0;
        src_nlfy = '0;
        for (int i = 0; i < NSRC; i++) len[i] = 4;
        tx_if.tx_rdy_vc0 = 1'b1;
        tx_if.tx_ca_ph_vc0 = 9'h100;
        tx_if.tx_ca_nph_vc0 = 9'h100;
        tx_if.tx_ca_cplh_vc0 = 9'h100;
        tx_if.tx_ca_pd_vc0 = 13'h1000;
        tx_if.tx_ca_npd_vc0 = 13'h1000;
        tx_if.tx_ca_cpld_vc0 = 13'h1000;
        tx_if.tx_ca_p_recheck_vc0 = 1'b0;
        tx_if.tx_ca_cpl_recheck_vc0 = 1'b0;

        step();
        step();
        check("reset gnt", 32'(src_gnt), 0);
        check("reset tx_req", 32'(tx_if.tx_req_vc0), 0);
        check("reset busy", 32'(arb_busy), 0);
        check("reset data", 32'(tx_if.tx_data_vc0), 0);
        check("reset abort/timeout", {src_abort, arb_timeout}, 0);

        // Round robin over three 4-beat posted TLPs, source 0 first.
        rst_n = 1'b1;
        src_req = 3'b111;
        run_tlp("rr0", 0, 4, 3'b111);
        run_tlp("rr1", 1, 4, 3'b111);
        run_tlp("rr2", 2, 4, 3'b111);
        run_tlp("rr3", 0, 4, 3'b000);

        // Credit gating: source 1 posted needs 8 data credits, only 5 advertised.
        src_cls = {2'd2, 2'd0, 2'd0};
        src_dcred = {9'd0, 9'd8, 9'd0};
        len[1] = 2;
        len[2] = 2;
        tx_if.tx_ca_pd_vc0 = 13'd5;
        src_req = 3'b110;
        run_tlp("cred cpl", 2, 2, 3'b010);
        step();
        check("cred blocked 1", 32'(src_gnt), 0);
        step();
        check("cred blocked 2", 32'(src_gnt), 0);
        tx_if.tx_ca_pd_vc0 = 13'd8;
        run_tlp("cred p", 1, 2, 3'b000);
        tx_if.tx_ca_pd_vc0 = 13'h1000;
        src_cls = '0;
        src_dcred = '0;

        // Watchdog: tx_rdy never returns.
        tx_if.tx_rdy_vc0 = 1'b0;
        src_req = 3'b001;
        wait_gnt("wd");
        check("wd gnt", 32'(src_gnt), 1);
        begin
            int n;
            n = 0;
            while (tx_if.tx_req_vc0 && n < 40) begin
                n++;
                step();
            end
            check("wd req cycles", n, TIMEOUT);
        end
        check("wd timeout pulse", 32'(arb_timeout), 1);
        check("wd abort", 32'(src_abort), 3'b001);
        check("wd busy", 32'(arb_busy), 0);
        check("wd gnt cleared", 32'(src_gnt), 0);
        src_req = 3'b000;
        step();
        check("wd pulse ends", {src_abort, arb_timeout}, 0);

        // Recheck in REQ: back to IDLE, no abort, same source wins again.
        src_req = 3'b011;
        wait_gnt("rchk");
        check("rchk gnt", 32'(src_gnt), 3'b001);
        tx_if.tx_ca_p_recheck_vc0 = 1'b1;
        step();
        tx_if.tx_ca_p_recheck_vc0 = 1'b0;
        #1;
        check("rchk idle", {arb_busy, tx_if.tx_req_vc0, src_gnt}, 0);
        check("rchk no abort", {src_abort, arb_timeout}, 0);
        step();
        check("rchk regrant", 32'(src_gnt), 3'b001);
        src_req = 3'b000;
        tx_if.tx_rdy_vc0 = 1'b1;
        wait_idle("rchk");

        // Link drop on beat 2 of a 4-beat TLP.
        len[1] = 4;
        src_req = 3'b010;
        wait_gnt("dl");
        check("dl gnt", 32'(src_gnt), 3'b010);
        step();
        check("dl beat1 st", {tx_if.tx_st_vc0, tx_if.tx_end_vc0}, 2'b10);
        step();
        dl_up = 1'b0;
        #1;
        check("dl beat2 no end", 32'(tx_if.tx_end_vc0), 0);
        step();
        check("dl abort", 32'(src_abort), 3'b010);
        check("dl idle", {arb_busy, src_gnt, tx_if.tx_end_vc0}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("dl held off", {src_gnt, src_abort, arb_busy}, 0);
        end
        dl_up = 1'b1;
        wait_gnt("dl up");
        check("dl regrant", 32'(src_gnt), 3'b010);
        src_req = 3'b000;
        step();
        check("dl restart data", 32'(tx_if.tx_data_vc0), 32'h1000);
        wait_idle("dl");

        // Single-beat nullified TLP; link falls on that same end beat.
        len[2] = 1;
        src_nlfy = 3'b100;
        src_req = 3'b100;
        wait_gnt("nlfy");
        check("nlfy gnt", 32'(src_gnt), 3'b100);
        src_req = 3'b000;
        step();
        dl_up = 1'b0;
        #1;
        check("nlfy st/end/nlfy", {tx_if.tx_st_vc0, tx_if.tx_end_vc0, tx_if.tx_nlfy_vc0}, 3'b111);
        check("nlfy rd", 32'(src_rd), 3'b100);
        step();
        check("nlfy no abort", {src_abort, arb_busy}, 0);
        dl_up = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
